// File: rtl/p11_phy_tx.sv
// USB 2.0 full-speed transmit PHY: SYNC, LSB-first bit stuffing, NRZI and EOP onto dp/dn.
// Optional packet abort input tx_abort_i is built only when P11_PHY_TX_ABORT_EN is defined.
module p11_phy_tx #(
  parameter int BIT_SAMPLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
`ifdef P11_PHY_TX_ABORT_EN
  input  logic       tx_abort_i,
`endif
  output logic       tx_ready_o,
  output logic       tx_en_o,
  output logic       dp_tx_o,
  output logic       dn_tx_o
);

  localparam int               CNT_W    = $clog2(BIT_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_SAMPLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_EOP   = 3'd3,
    ST_J     = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       shift_r;
  logic [3:0]       left_r;
  logic [2:0]       stuff_cnt_r;
  logic             stuffed_r;
  logic             line_r;
`ifdef P11_PHY_TX_ABORT_EN
  logic             abort_req_r;
`endif

  logic             strobe_s;
  logic             load_s;
  logic [3:0]       eff_left_s;
  logic [7:0]       eff_shift_s;
  logic             data_line_s;
  logic             abort_s;
  logic [CNT_W-1:0] cnt_next_s;

  function automatic logic nrzi_next(input logic level, input logic data_bit);
    return data_bit ? level : ~level;
  endfunction

  // Bit strobe, byte-load decision and the next NRZI level for the upcoming data bit.
  always_comb begin
    strobe_s    = (cnt_r == CNT_LAST);
    cnt_next_s  = strobe_s ? '0 : (cnt_r + CNT_W'(1));
    // left_r==0 on a data (non-stuffed) symbol marks the end of SYNC or of a byte
    load_s      = (left_r == 4'd0) && !stuffed_r && tx_valid_i;
    eff_left_s  = load_s ? 4'd8 : left_r;
    eff_shift_s = load_s ? tx_data_i : shift_r;
    data_line_s = nrzi_next(line_r, eff_shift_s[0]);
`ifdef P11_PHY_TX_ABORT_EN
    abort_s     = abort_req_r || tx_abort_i;
`else
    abort_s     = 1'b0;
`endif
  end

  // Transmit state machine with registered line drive and handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      shift_r     <= 8'h00;
      left_r      <= 4'd0;
      stuff_cnt_r <= 3'd0;
      stuffed_r   <= 1'b0;
      line_r      <= 1'b1;
      tx_ready_o  <= 1'b0;
      tx_en_o     <= 1'b0;
      dp_tx_o     <= 1'b1;
      dn_tx_o     <= 1'b0;
`ifdef P11_PHY_TX_ABORT_EN
      abort_req_r <= 1'b0;
`endif
    end else begin
      tx_ready_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r       <= '0;
          stuffed_r   <= 1'b0;
          stuff_cnt_r <= 3'd0;
          if (tx_valid_i) begin
            // first SYNC bit (a 0) goes out now; the remaining seven are 0000001 LSB-first
            state_r <= ST_SYNC;
            tx_en_o <= 1'b1;
            line_r  <= 1'b0;
            dp_tx_o <= 1'b0;
            dn_tx_o <= 1'b1;
            shift_r <= 8'h40;
            left_r  <= 4'd7;
          end else begin
            tx_en_o <= 1'b0;
            line_r  <= 1'b1;
            dp_tx_o <= 1'b1;
            dn_tx_o <= 1'b0;
            shift_r <= 8'h00;
            left_r  <= 4'd0;
          end
        end
        ST_SYNC, ST_DATA: begin
          cnt_r <= cnt_next_s;
`ifdef P11_PHY_TX_ABORT_EN
          abort_req_r <= (abort_req_r || tx_abort_i) && !strobe_s;
`endif
          if (strobe_s) begin
            if (abort_s) begin
              state_r   <= ST_ABORT;
              left_r    <= 4'd6;
              stuffed_r <= 1'b0;
            end else if (stuff_cnt_r == 3'd6) begin
              line_r      <= ~line_r;
              dp_tx_o     <= ~line_r;
              dn_tx_o     <= line_r;
              stuff_cnt_r <= 3'd0;
              stuffed_r   <= 1'b1;
              shift_r     <= eff_shift_s;
              left_r      <= eff_left_s;
              tx_ready_o  <= load_s;
              if (load_s) state_r <= ST_DATA;
            end else if (eff_left_s == 4'd0) begin
              state_r   <= ST_EOP;
              line_r    <= 1'b1;
              dp_tx_o   <= 1'b0;
              dn_tx_o   <= 1'b0;
              left_r    <= 4'd1;
              stuffed_r <= 1'b0;
            end else begin
              line_r      <= data_line_s;
              dp_tx_o     <= data_line_s;
              dn_tx_o     <= ~data_line_s;
              shift_r     <= {1'b0, eff_shift_s[7:1]};
              left_r      <= eff_left_s - 4'd1;
              stuffed_r   <= 1'b0;
              stuff_cnt_r <= eff_shift_s[0] ? (stuff_cnt_r + 3'd1) : 3'd0;
              tx_ready_o  <= load_s;
              if (load_s) state_r <= ST_DATA;
            end
          end
        end
`ifdef P11_PHY_TX_ABORT_EN
        ST_ABORT: begin
          cnt_r       <= cnt_next_s;
          abort_req_r <= 1'b0;
          if (strobe_s) begin
            if (left_r != 4'd0) begin
              left_r <= left_r - 4'd1;
            end else begin
              state_r <= ST_EOP;
              dp_tx_o <= 1'b0;
              dn_tx_o <= 1'b0;
              left_r  <= 4'd1;
            end
          end
        end
`endif
        ST_EOP: begin
          cnt_r <= cnt_next_s;
          if (strobe_s) begin
            if (left_r != 4'd0) begin
              left_r <= left_r - 4'd1;
            end else begin
              state_r <= ST_J;
              line_r  <= 1'b1;
              dp_tx_o <= 1'b1;
              dn_tx_o <= 1'b0;
            end
          end
        end
        ST_J: begin
          cnt_r <= cnt_next_s;
          if (strobe_s) begin
            state_r <= ST_IDLE;
            tx_en_o <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          line_r  <= 1'b1;
          tx_en_o <= 1'b0;
          dp_tx_o <= 1'b1;
          dn_tx_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
